// File: rtl/rr_mux_arb_if.sv
// Handshake bundle for rr_mux_arb: CH producer channels in, one registered beat out.
// in_last exists only when RR_MUX_ARB_LOCK_EN is defined.
interface rr_mux_arb_if #(
  parameter int N  = 32,
  parameter int CH = 4
);
  localparam int SEL_W = $clog2(CH);

  logic [CH*N-1:0]  in_data;
  logic [CH-1:0]    in_valid;
  logic [CH-1:0]    in_ready;
`ifdef RR_MUX_ARB_LOCK_EN
  logic [CH-1:0]    in_last;
`endif
  logic [N-1:0]     out_data;
  logic [SEL_W-1:0] out_ch;
  logic             out_valid;
  logic             out_ready;

  modport slave (
`ifdef RR_MUX_ARB_LOCK_EN
    input  in_last,
`endif
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_ch, out_valid
  );

  modport master (
`ifdef RR_MUX_ARB_LOCK_EN
    output in_last,
`endif
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_ch, out_valid
  );
endinterface

// File: rtl/rr_mux_arb.sv
// Round-robin CH:1 registered mux; 1 cycle accept-to-out_valid; one beat/cycle with out_ready=1.
// Stall (out_valid & !out_ready) holds the output and drops every in_ready; ptr only moves on a transfer.
// RR_MUX_ARB_LOCK_EN adds in_last and keeps the grant on one channel until its packet ends.
module rr_mux_arb #(
  parameter int N  = 32,
  parameter int CH = 4
) (
  input  logic        clk,
  input  logic        rst,
  rr_mux_arb_if.slave bus
);
  localparam int SEL_W = $clog2(CH);
  localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(CH - 1);
  localparam logic [SEL_W:0]   CH_EXT  = (SEL_W + 1)'(CH);

  logic [N-1:0]     ch_dat [CH];
  logic [SEL_W-1:0] ptr;
  logic [SEL_W-1:0] ptr_nxt;
  logic [SEL_W-1:0] gnt;
  logic             gnt_vld;
  logic [SEL_W:0]   sum;
  logic [SEL_W-1:0] cand;
  logic             free;
  logic             xfer;
  logic             ptr_upd;
  logic [CH-1:0]    rdy;

  logic [N-1:0]     out_data_q;
  logic [SEL_W-1:0] out_ch_q;
  logic             out_valid_q;

  for (genvar c = 0; c < CH; c++) begin : g_unpack
    assign ch_dat[c] = bus.in_data[c*N +: N];
  end

`ifdef RR_MUX_ARB_LOCK_EN
  typedef enum logic {S_ARB, S_LOCK} lock_state_t;
  lock_state_t      state;
  lock_state_t      state_nxt;
  logic [SEL_W-1:0] lock_ch;
`endif

  assign free = !out_valid_q || bus.out_ready;

  // Search starts at ptr and wraps; a locked packet pins the grant to its owner.
  always_comb begin
    gnt_vld = 1'b0;
    gnt     = '0;
    sum     = '0;
    cand    = '0;
`ifdef RR_MUX_ARB_LOCK_EN
    if (state == S_LOCK) begin
      gnt     = lock_ch;
      gnt_vld = bus.in_valid[lock_ch];
    end else begin
`endif
      for (int i = 0; i < CH; i++) begin
        sum = {1'b0, ptr} + (SEL_W + 1)'(i);
        if (sum >= CH_EXT) begin
          sum = sum - CH_EXT;
        end
        cand = sum[SEL_W-1:0];
        if (!gnt_vld && bus.in_valid[cand]) begin
          gnt_vld = 1'b1;
          gnt     = cand;
        end
      end
`ifdef RR_MUX_ARB_LOCK_EN
    end
`endif
  end

  assign xfer    = rst && free && gnt_vld;
  assign ptr_nxt = (gnt == LAST_CH) ? '0 : gnt + 1'b1;

`ifdef RR_MUX_ARB_LOCK_EN
  assign ptr_upd = xfer && bus.in_last[gnt];

  always_comb begin
    state_nxt = state;
    case (state)
      S_ARB:   if (xfer && !bus.in_last[gnt]) state_nxt = S_LOCK;
      S_LOCK:  if (xfer && bus.in_last[gnt])  state_nxt = S_ARB;
      default: state_nxt = S_ARB;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= S_ARB;
      lock_ch <= '0;
    end else begin
      state <= state_nxt;
      if (xfer) begin
        lock_ch <= gnt;
      end
    end
  end
`else
  assign ptr_upd = xfer;
`endif

  always_comb begin
    rdy = '0;
    if (xfer) begin
      rdy[gnt] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      out_data_q  <= '0;
      out_ch_q    <= '0;
      out_valid_q <= 1'b0;
      ptr         <= '0;
    end else begin
      if (xfer) begin
        out_data_q  <= ch_dat[gnt];
        out_ch_q    <= gnt;
        out_valid_q <= 1'b1;
      end else if (out_valid_q && bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
      if (ptr_upd) begin
        ptr <= ptr_nxt;
      end
    end
  end

  assign bus.in_ready  = rdy;
  assign bus.out_data  = out_data_q;
  assign bus.out_ch    = out_ch_q;
  assign bus.out_valid = out_valid_q;
endmodule

// File: tb/tb_rr_mux_arb.sv
// Directed bench for rr_mux_arb (CH=4, N=32): reset, sweep, idle-skip, stall, mid-stream reset, lock.
module tb_rr_mux_arb;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   errors = 0;
  int   checks = 0;

  rr_mux_arb_if #(.N(32), .CH(4)) bus ();

  rr_mux_arb #(.N(32), .CH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [1:0] ch, input logic [31:0] d);
    chk({tag, ".valid"}, 64'(bus.out_valid), 64'(v));
    chk({tag, ".ch"},    64'(bus.out_ch),    64'(ch));
    chk({tag, ".data"},  64'(bus.out_data),  64'(d));
  endtask

  task automatic chk_rdy(input string tag, input logic [3:0] exp);
    #1;
    chk(tag, 64'(bus.in_ready), 64'(exp));
  endtask

  initial begin
    bus.in_data   = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
    bus.in_valid  = 4'b1111;
    bus.out_ready = 1'b1;
`ifdef RR_MUX_ARB_LOCK_EN
    bus.in_last   = 4'b1111;
`endif
    #1;

    // reset held for two edges with every channel requesting
    for (int k = 0; k < 2; k++) begin
      step();
      chk_out("reset", 1'b0, 2'd0, 32'h0);
      chk_rdy("reset.rdy", 4'b0000);
    end

    rst = 1'b1;
    chk_rdy("first_grant", 4'b0001);

    // round-robin sweep
    for (int k = 0; k < 8; k++) begin
      step();
      chk_out($sformatf("sweep%0d", k), 1'b1, 2'(k % 4), 32'hA0 + 32'(k % 4));
    end

    // single grant of channel 1 moves ptr to 2
    bus.in_valid = 4'b0010;
    chk_rdy("ch1_only.rdy", 4'b0010);
    step();
    chk_out("ch1_only", 1'b1, 2'd1, 32'hA1);

    // channels 1 and 3 only, starting from ptr=2
    bus.in_valid = 4'b1010;
    for (int k = 0; k < 4; k++) begin
      chk_rdy($sformatf("skip%0d.rdy", k), (k % 2 == 0) ? 4'b1000 : 4'b0010);
      step();
      chk_out($sformatf("skip%0d", k), 1'b1, (k % 2 == 0) ? 2'd3 : 2'd1,
              (k % 2 == 0) ? 32'hA3 : 32'hA1);
    end

    // back-pressure with channel 2 holding DEADBEEF
    bus.in_data[95:64] = 32'hDEADBEEF;
    bus.in_valid = 4'b0100;
    chk_rdy("bp_load.rdy", 4'b0100);
    step();
    chk_out("bp_load", 1'b1, 2'd2, 32'hDEADBEEF);
    bus.out_ready = 1'b0;
    bus.in_valid  = 4'b1100;
    for (int k = 0; k < 3; k++) begin
      chk_rdy($sformatf("stall%0d.rdy", k), 4'b0000);
      step();
      chk_out($sformatf("stall%0d", k), 1'b1, 2'd2, 32'hDEADBEEF);
    end
    bus.out_ready = 1'b1;
    chk_rdy("bp_release.rdy", 4'b1000);
    step();
    chk_out("bp_release", 1'b1, 2'd3, 32'hA3);

    // reset asserted alongside a would-be beat from channel 1
    bus.in_data[95:64] = 32'hA2;
    bus.in_valid = 4'b0010;
    rst = 1'b0;
    chk_rdy("mid_rst.rdy", 4'b0000);
    step();
    chk_out("mid_rst", 1'b0, 2'd0, 32'h0);
    rst = 1'b1;
    bus.in_valid = 4'b1111;
    chk_rdy("post_rst.rdy", 4'b0001);
    step();
    chk_out("post_rst", 1'b1, 2'd0, 32'hA0);

    // drain to idle
    bus.in_valid = 4'b0000;
    step();
    chk("drain.valid", 64'(bus.out_valid), 64'd0);

`ifdef RR_MUX_ARB_LOCK_EN
    rst = 1'b0;
    step();
    rst = 1'b1;
    bus.in_valid = 4'b0011;
    bus.in_last  = 4'b0000;
    for (int k = 0; k < 3; k++) begin
      bus.in_last = (k == 2) ? 4'b0001 : 4'b0000;
      chk_rdy($sformatf("lock%0d.rdy", k), 4'b0001);
      step();
      chk_out($sformatf("lock%0d", k), 1'b1, 2'd0, 32'hA0);
    end
    bus.in_last = 4'b0010;
    chk_rdy("unlock.rdy", 4'b0010);
    step();
    chk_out("unlock", 1'b1, 2'd1, 32'hA1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/rr_mux_arb.md
Name: rr_mux_arb

Overview:
- Parametrised successor to the basic N-bit 4:1 select mux: a CH-input, N-bit registered multiplexer with per-channel valid/ready handshakes.
- Selection comes from an internal round-robin arbiter, not an external select.
- Used wherever several producers share one downstream consumer, such as register-file write-back or memory request merging in the datapath.
- Output is a single registered stage that reports the winning channel index alongside the data.

Parameters:
- N, 32, data width per channel in bits (N >= 1).
- CH, 4, number of input channels (2..16).
- SEL_W, $clog2(CH), width of the channel index. Derived; never overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-low reset.
- in_data  input  CH*N  channel c occupies bits [c*N+N-1 : c*N].
- in_valid  input  CH  per-channel request.
- in_ready  output  CH  per-channel accept. Combinational.
- out_data  output  N  registered data.
- out_ch  output  SEL_W  registered index of the channel that supplied out_data.
- out_valid  output  1  registered valid.
- out_ready  input  1  downstream accept.

Behaviour:
- Reset:
  - On a rising clk edge with rst == 0: out_valid = 0, out_data = 0, out_ch = 0, priority pointer ptr = 0.
  - in_ready is 0 for every channel while rst == 0.
  - Reset overrides any transfer in that same cycle; an in-flight beat is discarded.
- Slot free condition: free = !out_valid | out_ready.
- Grant:
  - Search channels in the order ptr, ptr+1, ..., CH-1, 0, ..., ptr-1, with modulo-CH wrap.
  - The first channel with in_valid set is the grant g.
  - If no channel is valid, there is no grant and in_ready = 0 for all channels.
- Ready: in_ready[c] = free & (c == g) & in_valid[c]. At most one bit is set per cycle.
- Input transfer: occurs when in_valid[g] & in_ready[g]. At the next edge:
  - out_data <= channel g data.
  - out_ch <= g.
  - out_valid <= 1.
  - ptr <= (g+1) mod CH. When g = CH-1, ptr wraps to 0.
- Output transfer:
  - Occurs when out_valid & out_ready.
  - If no new input transfer happens in the same cycle, out_valid <= 0.
  - If an input transfer also happens (full throughput), out_valid stays 1 and the register loads the new beat.
- Stall: while out_valid & !out_ready:
  - out_data, out_ch and out_valid hold.
  - in_ready = 0 for all channels.
  - ptr holds.
- ptr changes only on an input transfer. It never advances on idle or stall cycles.
- Latency and throughput: one cycle from input accept to out_valid. Sustained rate is one beat per cycle when out_ready is held at 1.
- Fairness: with all CH channels continuously valid, grants cycle 0, 1, ..., CH-1, 0, and so on. No channel waits more than CH-1 transfers.
- Channel independence: in_data and in_valid of non-granted channels have no effect on outputs.
- Non-power-of-two CH: out_ch never exceeds CH-1.

Optional Feature:
- Macro: RR_MUX_ARB_LOCK_EN.
- With the macro defined:
  - Adds input port in_last, width CH, one bit per channel marking the final beat of a packet.
  - After a transfer from channel g with in_last[g] == 0, the arbiter locks to g.
  - While locked, only g may be granted, even if other channels are valid.
  - ptr does not advance on a locked beat.
  - Lock releases on the transfer of a beat with in_last[g] == 1; ptr then becomes (g+1) mod CH.
  - Reset clears the lock.
- Without the macro: the in_last port is absent and every beat is arbitrated independently, as described in Behaviour.

Test Plan:
- Reset: rst=0 for 2 cycles with all in_valid = 4'b1111 and out_ready=1 -> out_valid=0, out_data=0, out_ch=0, in_ready=0. After release, the first grant is channel 0.
- Round-robin sweep: CH=4; all channels valid with data 32'hA0+c; out_ready=1 for 8 cycles -> out_ch sequence 0,1,2,3,0,1,2,3 with matching out_data; out_valid=1 continuously after the first beat.
- Skipping idle channels: only channels 1 and 3 valid; ptr starts at 2 -> grant order 3,1,3,1; in_ready[0] and in_ready[2] stay 0.
- Back-pressure: hold out_ready=0 for 3 cycles while a beat from channel 2 with 32'hDEADBEEF is held -> out_data, out_ch and out_valid are stable, in_ready=0 throughout. Raise out_ready -> the next grant is channel 3, not channel 2 again.
- Reset mid-stream: assert rst=0 in the same cycle as an accepted beat from channel 1 -> next cycle out_valid=0 and ptr=0; the beat is not emitted.
- Lock (RR_MUX_ARB_LOCK_EN defined): channel 0 sends 3 beats with in_last=0,0,1 while channel 1 is valid throughout -> out_ch = 0,0,0, then 1; in_ready[1] stays 0 during the packet.
